// File: rtl/stl_rst_seq_if.sv
// Request/reset bundle of the reset sequencer: asynchronous reset requests in,
// registered domain resets and status out.
interface stl_rst_seq_if;
  logic       sw_rst_req;
  logic       wdt_rst_req;
  logic       o_rst_periph;
  logic       o_rst_core;
  logic       o_rst_done;
  logic [1:0] o_rst_cause;

  modport master (
    output sw_rst_req,
    output wdt_rst_req,
    input  o_rst_periph,
    input  o_rst_core,
    input  o_rst_done,
    input  o_rst_cause
  );

  modport slave (
    input  sw_rst_req,
    input  wdt_rst_req,
    output o_rst_periph,
    output o_rst_core,
    output o_rst_done,
    output o_rst_cause
  );
endinterface

// File: rtl/stl_rst_seq.sv
// Reset sequencer: merges POR with software/watchdog requests, holds both domain
// resets for HOLD_CYCLES, then releases the peripheral domain STAGGER cycles before the core.
module stl_rst_seq #(
  parameter int HOLD_CYCLES = 16,
  parameter int STAGGER     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic          clk,
  input  logic          rst,
  stl_rst_seq_if.slave  bus
);

  localparam int CNT_MAX = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  localparam logic [1:0] ST_HOLD  = 2'b00;
  localparam logic [1:0] ST_REL_P = 2'b01;
  localparam logic [1:0] ST_RUN   = 2'b10;

  localparam logic [1:0] CAUSE_POR = 2'b00;
  localparam logic [1:0] CAUSE_SW  = 2'b01;
  localparam logic [1:0] CAUSE_WDT = 2'b10;

  logic [SYNC_STAGES-1:0] sw_sync_q;
  logic [SYNC_STAGES-1:0] wdt_sync_q;
  logic                   sw_prev_q;
  logic                   wdt_prev_q;
  logic                   sw_evt;
  logic                   wdt_evt;

  logic [1:0]       state_q,  state_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;
  logic             periph_q, periph_d;
  logic             core_q,   core_d;
  logic             done_q,   done_d;
  logic [1:0]       cause_q,  cause_d;

  // Request synchronizers and rising-edge detectors; prev flops clear on rst so a
  // request still high at release produces an event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_sync_q  <= '0;
      wdt_sync_q <= '0;
      sw_prev_q  <= 1'b0;
      wdt_prev_q <= 1'b0;
    end else begin
      sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], bus.sw_rst_req};
      wdt_sync_q <= {wdt_sync_q[SYNC_STAGES-2:0], bus.wdt_rst_req};
      sw_prev_q  <= sw_sync_q[SYNC_STAGES-1];
      wdt_prev_q <= wdt_sync_q[SYNC_STAGES-1];
    end
  end

  assign sw_evt  = sw_sync_q[SYNC_STAGES-1]  & ~sw_prev_q;
  assign wdt_evt = wdt_sync_q[SYNC_STAGES-1] & ~wdt_prev_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    periph_d = periph_q;
    core_d   = core_q;
    done_d   = done_q;
    cause_d  = cause_q;

    case (state_q)
      ST_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d  = ST_REL_P;
          cnt_d    = '0;
          periph_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_REL_P: begin
        if (cnt_q == STAG_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          core_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_RUN: begin
      end
      default: begin
        // Unreachable encoding: fall back into a full reset hold.
        state_d  = ST_HOLD;
        cnt_d    = '0;
        periph_d = 1'b1;
        core_d   = 1'b1;
        done_d   = 1'b0;
      end
    endcase

    // A request event overrides any terminal-count transition and restarts the hold.
    if (sw_evt || wdt_evt) begin
      state_d  = ST_HOLD;
      cnt_d    = '0;
      periph_d = 1'b1;
      core_d   = 1'b1;
      done_d   = 1'b0;
      cause_d  = wdt_evt ? CAUSE_WDT : CAUSE_SW;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_HOLD;
      cnt_q    <= '0;
      periph_q <= 1'b1;
      core_q   <= 1'b1;
      done_q   <= 1'b0;
      cause_q  <= CAUSE_POR;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      periph_q <= periph_d;
      core_q   <= core_d;
      done_q   <= done_d;
      cause_q  <= cause_d;
    end
  end

  assign bus.o_rst_periph = periph_q;
  assign bus.o_rst_core   = core_q;
  assign bus.o_rst_done   = done_q;
  assign bus.o_rst_cause  = cause_q;

endmodule

// File: tb/tb_stl_rst_seq.sv
// Directed bench for stl_rst_seq: edge-numbered stimulus and expectation tables,
// plus a hand-written asynchronous-reset sequence.
module tb_stl_rst_seq;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  stl_rst_seq_if bus ();

  stl_rst_seq #(
    .HOLD_CYCLES (16),
    .STAGGER     (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int   e;
    logic sw;
    logic wdt;
  } stim_t;

  typedef struct {
    int         e;
    logic       p;
    logic       c;
    logic       d;
    logic [1:0] cause;
  } exp_t;

  stim_t stim_q[$];
  exp_t  exp_q[$];

  int n_chk   = 0;
  int n_pass  = 0;
  int edge_no = 0;
  int inv_bad = 0;

  task automatic add_stim(input int e, input logic sw, input logic wdt);
    stim_t s;
    s.e = e; s.sw = sw; s.wdt = wdt;
    stim_q.push_back(s);
  endtask

  task automatic add_exp(input int e, input logic p, input logic c, input logic d,
                         input logic [1:0] cause);
    exp_t x;
    x.e = e; x.p = p; x.c = c; x.d = d; x.cause = cause;
    exp_q.push_back(x);
  endtask

  task automatic chk(input string name, input logic p, input logic c, input logic d,
                     input logic [1:0] cause);
    logic [4:0] act;
    logic [4:0] req;
    act = {bus.o_rst_periph, bus.o_rst_core, bus.o_rst_done, bus.o_rst_cause};
    req = {p, c, d, cause};
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s at edge %0d: periph/core/done/cause got %b required %b",
                  name, edge_no, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    edge_no++;
    if (bus.o_rst_core === 1'b0 && bus.o_rst_periph !== 1'b0) inv_bad++;
  endtask

  initial begin
    // Stimulus: level applied so that it is sampled at the listed edge.
    add_stim(100, 1'b1, 1'b0); add_stim(101, 1'b0, 1'b0);
    add_stim(200, 1'b0, 1'b1); add_stim(250, 1'b0, 1'b0);
    add_stim(300, 1'b1, 1'b0); add_stim(301, 1'b0, 1'b0);
    add_stim(310, 1'b0, 1'b1); add_stim(311, 1'b0, 1'b0);
    add_stim(350, 1'b1, 1'b0); add_stim(351, 1'b0, 1'b0);
    add_stim(400, 1'b1, 1'b1); add_stim(401, 1'b0, 1'b0);

    // POR release
    add_exp(1,   1, 1, 0, 2'b00); add_exp(15,  1, 1, 0, 2'b00);
    add_exp(16,  0, 1, 0, 2'b00); add_exp(19,  0, 1, 0, 2'b00);
    add_exp(20,  0, 0, 1, 2'b00); add_exp(50,  0, 0, 1, 2'b00);
    // SW request in RUN
    add_exp(101, 0, 0, 1, 2'b00); add_exp(102, 1, 1, 0, 2'b01);
    add_exp(117, 1, 1, 0, 2'b01); add_exp(118, 0, 1, 0, 2'b01);
    add_exp(121, 0, 1, 0, 2'b01); add_exp(122, 0, 0, 1, 2'b01);
    // WDT held level: single sequence, no retrigger
    add_exp(201, 0, 0, 1, 2'b01); add_exp(202, 1, 1, 0, 2'b10);
    add_exp(217, 1, 1, 0, 2'b10); add_exp(218, 0, 1, 0, 2'b10);
    add_exp(222, 0, 0, 1, 2'b10); add_exp(240, 0, 0, 1, 2'b10);
    add_exp(255, 0, 0, 1, 2'b10); add_exp(270, 0, 0, 1, 2'b10);
    // Restart during hold
    add_exp(302, 1, 1, 0, 2'b01); add_exp(311, 1, 1, 0, 2'b01);
    add_exp(312, 1, 1, 0, 2'b10); add_exp(318, 1, 1, 0, 2'b10);
    add_exp(327, 1, 1, 0, 2'b10); add_exp(328, 0, 1, 0, 2'b10);
    add_exp(331, 0, 1, 0, 2'b10); add_exp(332, 0, 0, 1, 2'b10);
    // SW sequence to set cause 01, then simultaneous SW+WDT
    add_exp(352, 1, 1, 0, 2'b01); add_exp(368, 0, 1, 0, 2'b01);
    add_exp(372, 0, 0, 1, 2'b01); add_exp(401, 0, 0, 1, 2'b01);
    add_exp(402, 1, 1, 0, 2'b10); add_exp(418, 0, 1, 0, 2'b10);
    add_exp(422, 0, 0, 1, 2'b10); add_exp(430, 0, 0, 1, 2'b10);

    rst = 1'b1;
    bus.sw_rst_req  = 1'b0;
    bus.wdt_rst_req = 1'b0;
    #1;
    chk("reset_state", 1, 1, 0, 2'b00);
    #1;
    rst = 1'b0;

    for (int e = 1; e <= 430; e++) begin
      foreach (stim_q[i]) begin
        if (stim_q[i].e == e) begin
          bus.sw_rst_req  = stim_q[i].sw;
          bus.wdt_rst_req = stim_q[i].wdt;
        end
      end
      step();
      foreach (exp_q[i]) begin
        if (exp_q[i].e == e)
          chk($sformatf("vec%0d", i), exp_q[i].p, exp_q[i].c, exp_q[i].d, exp_q[i].cause);
      end
    end

    // SW event at edge 431, then async rst while in REL_P
    bus.sw_rst_req = 1'b1;
    step();
    bus.sw_rst_req = 1'b0;
    step();
    step();
    chk("sw_before_rst", 1, 1, 0, 2'b01);
    repeat (16) step();
    chk("in_rel_p", 0, 1, 0, 2'b01);
    step();
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_now", 1, 1, 0, 2'b00);
    step();
    chk("rst_held", 1, 1, 0, 2'b00);
    #2;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 15) chk("por2_k15", 1, 1, 0, 2'b00);
      if (k == 16) chk("por2_k16", 0, 1, 0, 2'b00);
      if (k == 19) chk("por2_k19", 0, 1, 0, 2'b00);
      if (k == 20) chk("por2_k20", 0, 0, 1, 2'b00);
    end

    n_chk++;
    if (inv_bad == 0) n_pass++;
    else $display("FAIL invariant core_released_periph_in_reset: got %0d violations required 0", inv_bad);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/stl_rst_seq.md
# stl_rst_seq

Reset sequencer. It produces the design's reset pulses, whose release the per-domain reset synchronizers then align. It merges the power-on reset with software and watchdog reset requests, then holds all downstream resets for a programmable minimum time. It releases the peripheral domain first and the core domain a fixed number of cycles later, and records the cause of the last reset. It sits at the top of the NPC, ahead of the per-domain synchronizers.

## Interface
- HOLD_CYCLES, 16, cycles both resets stay asserted after the last reset event (≥1)
- STAGGER, 4, cycles between peripheral release and core release (≥1)
- SYNC_STAGES, 2, flop depth of each request synchronizer (≥2)

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  power-on reset, asynchronous, active-high
- sw_rst_req  in  1  software reset request, asynchronous source, level ≥1 clk cycle wide
- wdt_rst_req  in  1  watchdog reset request, asynchronous source, level
- o_rst_periph  out  1  peripheral-domain reset, active-high, registered
- o_rst_core  out  1  core-domain reset, active-high, registered
- o_rst_done  out  1  high once both resets are released
- o_rst_cause  out  2  cause of the last reset: 00 POR, 01 SW, 10 WDT, 11 unused

## Operation
- rst asserted (asynchronous): state=HOLD, cnt=0, o_rst_periph=1, o_rst_core=1, o_rst_done=0, o_rst_cause=00, all synchronizer and edge-detect flops cleared to 0.
- Each request passes through a SYNC_STAGES flop chain and then a rising-edge detector (last stage AND NOT its registered previous value).
- A held level therefore produces one event only. A new event requires the request to drop and rise again.
- States:
  - HOLD: cnt increments every edge. When cnt==HOLD_CYCLES-1: go to REL_P, cnt=0, o_rst_periph←0.
  - REL_P: cnt increments every edge. When cnt==STAGGER-1: go to RUN, o_rst_core←0, o_rst_done←1.
  - RUN: idle, counter frozen.
- A request event in any state forces on the next edge: state=HOLD, cnt=0, o_rst_periph←1, o_rst_core←1, o_rst_done←0, cause updated.
  - Events in HOLD or REL_P restart the hold count. Resets never release early.
- Simultaneous SW and WDT events: cause=10 (WDT has priority).
- A request event takes priority over the counter-terminal transition in the same cycle.
- cnt width is $clog2(max(HOLD_CYCLES,STAGGER)+1). The counter never wraps, because it is cleared on every transition.
- o_rst_cause changes only on a reset event. It is held through RUN until the next event or rst.
- o_rst_core=0 implies o_rst_periph=0 at all times. The peripheral domain is never in reset while the core runs.

## Timing
- All outputs are driven directly from flops, with no combinational path from any input.
- POR: rst deasserts before edge 1.
  - o_rst_periph falls after edge HOLD_CYCLES.
  - o_rst_core and o_rst_done change after edge HOLD_CYCLES+STAGGER.
- Request sampled high at edge E:
  - Both resets rise after edge E+SYNC_STAGES.
  - Peripheral release follows HOLD_CYCLES edges later.
  - Core release and done follow STAGGER edges after that.
- rst asserted mid-sequence or in RUN: outputs return to their reset values immediately, with no clock needed.
- Requests present during rst: ignored. If a request level is still high after rst release, it produces an event on release, because the edge detector's previous-value flop resets to 0.

## Test plan
- POR, defaults: release rst before edge 1 → o_rst_periph=0 after edge 16, o_rst_core=0 and o_rst_done=1 after edge 20, o_rst_cause=00.
- SW request in RUN: sw_rst_req high 1 cycle, sampled at edge 100 → both resets=1 and done=0 after edge 102, periph release after edge 118, core release after edge 122, cause=01.
- WDT level held high 50 cycles from edge 200 → exactly one reset sequence (resets after 202, core release after 222), cause=10, no retrigger while the level stays high.
- Restart during hold: SW event sampled at edge 300, then WDT event sampled at edge 310 → resets stay asserted continuously, periph release after edge 328, core release after edge 332, cause=10.
- Simultaneous SW+WDT rising at the same edge → one sequence, cause=10. The invariant "o_rst_core=0 ⇒ o_rst_periph=0" is checked every cycle.
- Async rst pulse mid-REL_P (not aligned to clk) → outputs=1/1/0 and cause=00 immediately. The POR timing of scenario 1 repeats from the release.
